// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with an on-the-fly iterative key schedule.
// Registers data_in ^ round_key and hands it downstream over valid/ready.
module add_round_key_stage #(
  parameter int unsigned NR        = 10,
  parameter bit          KEY_CLEAR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [3:0]   round_out,
  output logic         last_round,
  output logic         busy
);

  localparam logic [3:0] LastRnd = 4'(NR);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;
  logic         xfer;
  logic [31:0]  sub_w;
  logic [127:0] rk_next;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from first principles: inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // SubWord(RotWord(w3)): rotation folded into the byte selection.
  always_comb begin
    sub_w = {sbox(rk_q[23:16]), sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
    rk_next[127:96] = rk_q[127:96] ^ sub_w ^ {rcon_q, 24'h0};
    rk_next[95:64]  = rk_q[95:64] ^ rk_next[127:96];
    rk_next[63:32]  = rk_q[63:32] ^ rk_next[95:64];
    rk_next[31:0]   = rk_q[31:0]  ^ rk_next[63:32];
  end

  assign in_ready = (state_q == StActive) && (!valid_q || out_ready);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StActive;
          rk_d    = key_in;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      StActive: begin
        if (xfer) begin
          if (rnd_q != LastRnd) rk_d = rk_next;
          rnd_d  = rnd_q + 4'd1;
          rcon_d = xtime(rcon_q);
          if (rnd_q == LastRnd) begin
            state_d = StIdle;
            if (KEY_CLEAR) rk_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    round_d = round_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (xfer) begin
      data_d  = data_in ^ rk_q;
      round_d = rnd_q;
      last_d  = (rnd_q == LastRnd);
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rk_q    <= '0;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      data_q  <= '0;
      round_q <= 4'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      data_q  <= data_d;
      round_q <= round_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign data_out   = data_q;
  assign round_out  = round_q;
  assign last_round = last_q;
  assign busy       = (state_q == StActive);

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage using FIPS-197 key-expansion vectors.
module tb_add_round_key_stage;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   round_out;
  logic         last_round;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [127:0] key1;
  logic [127:0] key2;
  logic [127:0] rk1 [0:10];

  add_round_key_stage #(.NR(10), .KEY_CLEAR(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .round_out  (round_out),
    .last_round (last_round),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One transfer: waits (bounded) for in_ready, then samples #1 after the edge.
  task automatic xfer(input logic [127:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    data_in  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check_eq("in_ready_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_key1(input int from, input int to, input string tag);
    for (int r = from; r <= to; r++) begin
      xfer(128'h0);
      check_eq({tag, "_data"}, data_out, rk1[r]);
      check_eq({tag, "_round"}, 128'(round_out), 128'(r));
      check_eq({tag, "_last"}, 128'(last_round), 128'(r == 10));
    end
  endtask

  initial begin
    key1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key2 = 128'h000102030405060708090a0b0c0d0e0f;
    rk1[0]  = key1;
    rk1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0; start = 1'b0; key_in = '0; in_valid = 1'b0;
    data_in = '0; out_ready = 1'b1;
    #23;
    check_eq("rst_out_valid", 128'(out_valid), 128'd0);
    check_eq("rst_in_ready", 128'(in_ready), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_data_out", data_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: FIPS-197 A.1 key, all-zero state.
    do_start(key1);
    check_eq("s1_busy_start", 128'(busy), 128'd1);
    check_eq("s1_in_ready", 128'(in_ready), 128'd1);
    run_key1(0, 10, "s1");
    check_eq("s1_busy_end", 128'(busy), 128'd0);

    // 2: FIPS-197 C.1 key.
    do_start(key2);
    xfer(128'h00112233445566778899aabbccddeeff);
    check_eq("s2_r0", data_out, 128'h00102030405060708090a0b0c0d0e0f0);
    xfer(128'h0);
    check_eq("s2_r1", data_out, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    for (int r = 2; r <= 10; r++) xfer(128'h0);
    check_eq("s2_r10", data_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_eq("s2_last", 128'(last_round), 128'd1);

    // 3: backpressure after round 2.
    do_start(key1);
    run_key1(0, 2, "s3");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 128'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("s3_hold_ready", 128'(in_ready), 128'd0);
      check_eq("s3_hold_data", data_out, rk1[2]);
      check_eq("s3_hold_round", 128'(round_out), 128'd2);
      check_eq("s3_hold_valid", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("s3_release_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("s3_r3_data", data_out, rk1[3]);
    check_eq("s3_r3_round", 128'(round_out), 128'd3);
    run_key1(4, 10, "s3");

    // 4: full throughput.
    do_start(key1);
    in_valid = 1'b1;
    data_in  = 128'h0;
    for (int r = 0; r <= 10; r++) begin
      check_eq("s4_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      check_eq("s4_data", data_out, rk1[r]);
      check_eq("s4_round", 128'(round_out), 128'(r));
      check_eq("s4_valid", 128'(out_valid), 128'd1);
    end
    in_valid = 1'b0;
    check_eq("s4_busy_end", 128'(busy), 128'd0);

    // 5: start mid-run with another key is ignored.
    do_start(key1);
    run_key1(0, 3, "s5");
    start  = 1'b1;
    key_in = key2;
    xfer(128'h0);
    start = 1'b0;
    check_eq("s5_r4", data_out, rk1[4]);
    run_key1(5, 10, "s5");

    // 6: asynchronous reset during round 6, then a clean rerun.
    do_start(key1);
    run_key1(0, 5, "s6");
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("s6_rst_valid", 128'(out_valid), 128'd0);
    check_eq("s6_rst_data", data_out, 128'h0);
    check_eq("s6_rst_round", 128'(round_out), 128'd0);
    check_eq("s6_rst_last", 128'(last_round), 128'd0);
    check_eq("s6_rst_busy", 128'(busy), 128'd0);
    check_eq("s6_rst_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_start(key1);
    run_key1(0, 10, "s6b");
    check_eq("s6_busy_end", 128'(busy), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
